// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port among N_REQ valid/ready producers,
// granting one producer at a time for a burst of at most MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DW-1:0]        req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DW-1:0]              fifo_wr_data,
  output logic                       grant_vld,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic [IW-1:0]   owner_inc;
  logic            own_valid;
  logic            own_last;
  logic [DW-1:0]   own_data;
  logic            in_burst;
  logic            beat;
  logic            cap_hit;

  // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        winner  = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    own_valid = req_valid[owner_q];
    own_last  = req_last[owner_q];
    own_data  = req_data[int'(owner_q)*DW +: DW];
    owner_inc = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  // Reset low suppresses any transfer in the same cycle.
  assign in_burst = (state_q == BURST) && rst;
  assign beat     = in_burst && own_valid && !fifo_full;
  assign cap_hit  = (beat_cnt_q + 1'b1) == CW'(MAX_BURST);

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) req_ready[owner_q] = 1'b1;
    fifo_wr_en   = beat;
    fifo_wr_data = beat ? own_data : '0;
    grant_vld    = (state_q == BURST);
    grant_id     = owner_q;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BURST;
          owner_d    = winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (own_last || cap_hit) begin
            state_d  = IDLE;
            rr_ptr_d = owner_inc;
          end
        end else if (!own_valid && !fifo_full) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 8-bit synchronous FIFO between several producers. Each producer offers bytes through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `wr_en`/`wr_data` pins, back-pressuring on FIFO `full`. It sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
- `N_REQ`, 4: number of producers, 2..8.
- `DW`, 8: data width; must match the FIFO.
- `MAX_BURST`, 4: maximum beats per grant, 1..15.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset is synchronous and active-low (asserted when 0, sampled on `clk`).
- `req_valid`  in  N_REQ: producer i has a byte on offer.
- `req_data`  in  N_REQ*DW: producer i byte at bits [i*DW +: DW].
- `req_last`  in  N_REQ: current byte of producer i ends its burst.
- `req_ready`  out  N_REQ: one-hot or zero; byte of producer i is accepted this cycle when valid&ready.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_wr_en`  out  1: FIFO write enable.
- `fifo_wr_data`  out  DW: FIFO write data.
- `grant_vld`  out  1: a burst grant is active.
- `grant_id`  out  $clog2(N_REQ): owner of the active grant.

## Operation
- State machine, two states:
  - `IDLE`: no grant.
  - `BURST`: grant held by `owner`.
- Registers: `state`, `owner`, `rr_ptr` (highest-priority index), `beat_cnt` ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If any `req_valid`, the winner is the first set bit scanning `rr_ptr`, `rr_ptr+1`, ... modulo N_REQ.
  - Next cycle: `owner`=winner, `beat_cnt`=0, state BURST. No byte is transferred in the arbitration cycle.
- BURST:
  - `req_ready[owner] = !fifo_full`; all other `req_ready` = 0.
  - Beat: `req_valid[owner] & req_ready[owner]`.
  - `fifo_wr_en` = beat, and `fifo_wr_data = req_data[owner]` in the same cycle (combinational path).
  - `fifo_wr_data` = 0 whenever `fifo_wr_en` = 0.
  - Each beat increments `beat_cnt`.
- BURST exit to IDLE at the clock edge after any of:
  - a beat with `req_last[owner]`=1;
  - the beat that makes `beat_cnt`==MAX_BURST;
  - a cycle with `req_valid[owner]`=0 and `fifo_full`=0 (producer withdrew).
- On exit, `rr_ptr` = (`owner`+1) mod N_REQ. `rr_ptr` changes only on exit.
- `fifo_full` while in BURST: stall in BURST indefinitely, no beats, `beat_cnt` held; no timeout, grant not released.
- Non-owner `req_valid` has no effect until IDLE. Producers must hold valid/data/last stable until accepted.
- `grant_vld` = (state==BURST). `grant_id` = `owner` (registered); holds its last value in IDLE.

## Timing
- Reset (`rst`=0 at an edge):
  - `state`=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0.
  - All outputs 0: `req_ready`, `fifo_wr_en`, `fifo_wr_data`, `grant_vld`, `grant_id`.
- Reset mid-burst aborts the grant. A byte presented in the reset cycle is not written.
- Latency:
  - Arbitration: 1 cycle from valid seen in IDLE to first possible beat.
  - Full-rate burst of k beats occupies k+1 cycles.
  - Back-to-back bursts always have one IDLE cycle between them.
- `fifo_full` is sampled combinationally the same cycle. A write is never issued while `fifo_full`=1.
- Width rules: `beat_cnt` never exceeds MAX_BURST. `rr_ptr`/`owner` wrap modulo N_REQ; N_REQ that is not a power of two must still wrap correctly.
- MAX_BURST=1: every grant is exactly one beat.

## Test plan
- Single producer: reset, `req_valid[2]`=1 with bytes 0xA1,0xA2,0xA3 (last on 0xA3) -> `grant_id`=2 one cycle later; `fifo_wr_en` high 3 consecutive cycles with 0xA1..0xA3; IDLE after; `rr_ptr`=3.
- Fairness: all four valid continuously, single-beat bursts (`req_last`=1) -> grant order 0,1,2,3,0,1; each write separated by one idle cycle.
- Burst cap: producer 0 streams 10 bytes with `req_last`=0, producer 1 valid, MAX_BURST=4 -> writes 4 bytes from 0, then 1 gets the grant, then 0 resumes with byte 5.
- Full back-pressure: `fifo_full` forced 1 after 2nd beat for 5 cycles -> `req_ready`=0 and `fifo_wr_en`=0 for those 5 cycles; grant held; 3rd byte written the cycle `fifo_full` drops.
- Withdrawal and reset: owner drops valid mid-burst with FIFO not full -> IDLE next edge, pointer advances. Separately, `rst`=0 during a beat -> no write that cycle; all outputs 0 next cycle; `rr_ptr`=0.
- End-to-end with the FIFO: 15 bytes from 3 producers -> FIFO reaches full, 16th byte stalls; FIFO contents match per-producer order.
